// File: rtl/tlb_lookup_responder.sv
// TLB entry array with two independent combinational search ports (fetch / execute+probe),
// a single-entry write port for TLBWI/TLBWR and a combinational read port for TLBR.
module tlb_lookup_responder #(
   parameter int TLBNUM = 16,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [18:0]      s0_vpn2,
   input  logic             s0_odd_page,
   input  logic [7:0]       s0_asid,
   output logic             s0_found,
   output logic [IDX_W-1:0] s0_index,
   output logic [19:0]      s0_pfn,
   output logic [2:0]       s0_c,
   output logic             s0_d,
   output logic             s0_v,
   input  logic [18:0]      s1_vpn2,
   input  logic             s1_odd_page,
   input  logic [7:0]       s1_asid,
   output logic             s1_found,
   output logic [IDX_W-1:0] s1_index,
   output logic [19:0]      s1_pfn,
   output logic [2:0]       s1_c,
   output logic             s1_d,
   output logic             s1_v,
   input  logic             we,
   input  logic [IDX_W-1:0] w_index,
   input  logic [18:0]      w_vpn2,
   input  logic [7:0]       w_asid,
   input  logic             w_g,
   input  logic [19:0]      w_pfn0,
   input  logic [2:0]       w_c0,
   input  logic             w_d0,
   input  logic             w_v0,
   input  logic [19:0]      w_pfn1,
   input  logic [2:0]       w_c1,
   input  logic             w_d1,
   input  logic             w_v1,
   input  logic [IDX_W-1:0] r_index,
   output logic [18:0]      r_vpn2,
   output logic [7:0]       r_asid,
   output logic             r_g,
   output logic [19:0]      r_pfn0,
   output logic [2:0]       r_c0,
   output logic             r_d0,
   output logic             r_v0,
   output logic [19:0]      r_pfn1,
   output logic [2:0]       r_c1,
   output logic             r_d1,
   output logic             r_v1
);

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } entry_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] index;
      logic [19:0]      pfn;
      logic [2:0]       c;
      logic             d;
      logic             v;
   } result_t;

   entry_t            r_entry [TLBNUM];
   logic [TLBNUM-1:0] r_present;
   result_t           w_s0Result;
   result_t           w_s1Result;

   // Reset wipes contents as well as presence so TLBR of a never-written entry reads zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) begin
            r_entry[i] <= '0;
         end
         r_present <= '0;
      end else if (we) begin
         r_entry[w_index] <= '{w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                               w_pfn1, w_c1, w_d1, w_v1};
         r_present[w_index] <= 1'b1;
      end
   end

   // Scanning from the top down lets the lowest matching index overwrite any higher one.
   function automatic result_t lookup(input logic [18:0] vpn2, input logic odd,
                                      input logic [7:0] asid);
      result_t res;
      res = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (r_present[i] && r_entry[i].vpn2 == vpn2 &&
             (r_entry[i].g || r_entry[i].asid == asid)) begin
            res.found = 1'b1;
            res.index = IDX_W'(i);
            if (odd) begin
               res.pfn = r_entry[i].pfn1;
               res.c   = r_entry[i].c1;
               res.d   = r_entry[i].d1;
               res.v   = r_entry[i].v1;
            end else begin
               res.pfn = r_entry[i].pfn0;
               res.c   = r_entry[i].c0;
               res.d   = r_entry[i].d0;
               res.v   = r_entry[i].v0;
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      w_s0Result = lookup(s0_vpn2, s0_odd_page, s0_asid);
      w_s1Result = lookup(s1_vpn2, s1_odd_page, s1_asid);
   end

   assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} = w_s0Result;
   assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} = w_s1Result;

   assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
           r_pfn1, r_c1, r_d1, r_v1} = r_entry[r_index];

endmodule

// File: tb/tb_tlb_lookup_responder.sv
// Self-checking bench for tlb_lookup_responder: directed scenarios plus randomized
// writes/searches/reads compared against an array-based reference model.
module tb_tlb_lookup_responder;

   localparam int TLBNUM = 16;
   localparam int IDX_W  = 4;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlbEntry_t;

   logic clk = 1'b0;
   logic reset;
   logic [18:0] s0_vpn2, s1_vpn2;
   logic s0_odd_page, s1_odd_page;
   logic [7:0] s0_asid, s1_asid;
   logic s0_found, s1_found;
   logic [IDX_W-1:0] s0_index, s1_index;
   logic [19:0] s0_pfn, s1_pfn;
   logic [2:0] s0_c, s1_c;
   logic s0_d, s0_v, s1_d, s1_v;
   logic we;
   logic [IDX_W-1:0] w_index, r_index;
   logic [18:0] w_vpn2, r_vpn2;
   logic [7:0] w_asid, r_asid;
   logic w_g, r_g;
   logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
   logic [2:0] w_c0, w_c1, r_c0, r_c1;
   logic w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;

   int checks = 0;
   int errors = 0;

   tlbEntry_t mEntry [TLBNUM];
   logic [TLBNUM-1:0] mPresent;
   int pendIdx;
   tlbEntry_t pendEntry;
   logic [18:0] vpn2Pool [4] = '{19'h00001, 19'h12345, 19'h7FFFF, 19'h2A2A2};

   tlb_lookup_responder #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset),
      .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
      .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
      .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
      .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
      .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
      .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
      .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
      .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
   );

   always #5 clk = ~clk;

   // Reference search: first present entry whose tag matches, else all zeros.
   function automatic logic [29:0] modelSearch(input logic [18:0] vpn2, input logic odd,
                                               input logic [7:0] asid);
      for (int i = 0; i < TLBNUM; i++) begin
         if (mPresent[i] && mEntry[i].vpn2 == vpn2 && (mEntry[i].g || mEntry[i].asid == asid)) begin
            if (odd)
               return {1'b1, IDX_W'(i), mEntry[i].pfn1, mEntry[i].c1, mEntry[i].d1, mEntry[i].v1};
            else
               return {1'b1, IDX_W'(i), mEntry[i].pfn0, mEntry[i].c0, mEntry[i].d0, mEntry[i].v0};
         end
      end
      return 30'd0;
   endfunction

   function automatic tlbEntry_t randEntry();
      tlbEntry_t e;
      e.vpn2 = vpn2Pool[$urandom_range(0, 3)];
      e.asid = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h09;
      e.g    = ($urandom_range(0, 3) == 0);
      e.pfn0 = 20'($urandom);
      e.c0   = 3'($urandom);
      e.d0   = 1'($urandom);
      e.v0   = 1'($urandom);
      e.pfn1 = 20'($urandom);
      e.c1   = 3'($urandom);
      e.d1   = 1'($urandom);
      e.v1   = 1'($urandom);
      return e;
   endfunction

   function automatic tlbEntry_t mkEntry(input logic [18:0] vpn2, input logic [7:0] asid,
                                         input logic g, input logic [19:0] pfn0,
                                         input logic v0, input logic d0,
                                         input logic [19:0] pfn1, input logic v1,
                                         input logic d1);
      tlbEntry_t e;
      e = '{vpn2, asid, g, pfn0, 3'd3, d0, v0, pfn1, 3'd5, d1, v1};
      return e;
   endfunction

   task automatic driveWrite(input int idx, input tlbEntry_t e);
      @(negedge clk);
      we = 1'b1;
      w_index = IDX_W'(idx);
      {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = e;
      pendIdx = idx;
      pendEntry = e;
   endtask

   task automatic commitWrite();
      @(posedge clk);
      #1;
      we = 1'b0;
      mEntry[pendIdx] = pendEntry;
      mPresent[pendIdx] = 1'b1;
   endtask

   task automatic writeEntry(input int idx, input tlbEntry_t e);
      driveWrite(idx, e);
      commitWrite();
   endtask

   task automatic setS0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
      s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
   endtask

   task automatic setS1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
      s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
   endtask

   task automatic clearModel();
      for (int i = 0; i < TLBNUM; i++) mEntry[i] = '0;
      mPresent = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      we = 1'b0;
      w_index = '0;
      {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = '0;
      setS0(19'h0, 1'b0, 8'h0);
      setS1(19'h0, 1'b0, 8'h0);
      r_index = 4'd5;
      clearModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== 30'd0) begin
         errors++;
         $display("[TB] FAIL reset_s0 got=%h want=0", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v});
      end
      checks++;
      if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== 30'd0) begin
         errors++;
         $display("[TB] FAIL reset_s1 got=%h want=0", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
      end
      checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== 78'd0) begin
         errors++;
         $display("[TB] FAIL reset_read got=%h want=0",
                  {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1});
      end
   endtask

   task automatic test_basic();
      writeEntry(3, mkEntry(19'h12345, 8'h07, 1'b0, 20'hAAAAA, 1'b1, 1'b0, 20'hBBBBB, 1'b1, 1'b1));
      @(negedge clk);
      setS1(19'h12345, 1'b1, 8'h07);
      r_index = 4'd3;
      #1;
      checks++;
      if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== {1'b1, 4'd3, 20'hBBBBB, 3'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL basic_odd got=%h want=%h", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
                  {1'b1, 4'd3, 20'hBBBBB, 3'd5, 1'b1, 1'b1});
      end
      checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== mEntry[3]) begin
         errors++;
         $display("[TB] FAIL basic_read got=%h want=%h",
                  {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}, mEntry[3]);
      end
      setS1(19'h12345, 1'b0, 8'h07);
      #1;
      checks++;
      if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== {1'b1, 4'd3, 20'hAAAAA, 3'd3, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL basic_even got=%h want=%h", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
                  {1'b1, 4'd3, 20'hAAAAA, 3'd3, 1'b0, 1'b1});
      end
      setS1(19'h12345, 1'b0, 8'h08);
      #1;
      checks++;
      if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== 30'd0) begin
         errors++;
         $display("[TB] FAIL basic_asid_miss got=%h want=0", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
      end
   endtask

   task automatic test_global();
      driveWrite(3, mkEntry(19'h12345, 8'h07, 1'b1, 20'hAAAAA, 1'b1, 1'b0, 20'hCCCCC, 1'b1, 1'b1));
      setS0(19'h12345, 1'b1, 8'hFF);
      setS1(19'h12345, 1'b1, 8'h07);
      #1;
      checks++;
      if (s0_found !== 1'b0) begin
         errors++;
         $display("[TB] FAIL global_writecycle_s0 got=%b want=0", s0_found);
      end
      checks++;
      if (s1_pfn !== 20'hBBBBB) begin
         errors++;
         $display("[TB] FAIL global_writecycle_s1 got=%h want=bbbbb", s1_pfn);
      end
      commitWrite();
      @(negedge clk);
      setS1(19'h12345, 1'b1, 8'hFF);
      #1;
      checks++;
      if ({s1_found, s1_index, s1_pfn} !== {1'b1, 4'd3, 20'hCCCCC}) begin
         errors++;
         $display("[TB] FAIL global_hit got=%h want=%h", {s1_found, s1_index, s1_pfn}, {1'b1, 4'd3, 20'hCCCCC});
      end
   endtask

   task automatic test_multi_match();
      writeEntry(9, mkEntry(19'h00ABC, 8'h11, 1'b0, 20'h99999, 1'b1, 1'b0, 20'h99990, 1'b1, 1'b0));
      writeEntry(2, mkEntry(19'h00ABC, 8'h11, 1'b0, 20'h22222, 1'b1, 1'b1, 20'h22220, 1'b1, 1'b0));
      @(negedge clk);
      setS0(19'h00ABC, 1'b0, 8'h11);
      #1;
      checks++;
      if ({s0_found, s0_index, s0_pfn, s0_d} !== {1'b1, 4'd2, 20'h22222, 1'b1}) begin
         errors++;
         $display("[TB] FAIL multi_match got=%h want=%h", {s0_found, s0_index, s0_pfn, s0_d},
                  {1'b1, 4'd2, 20'h22222, 1'b1});
      end
   endtask

   task automatic test_invalid();
      writeEntry(6, mkEntry(19'h55555, 8'h01, 1'b0, 20'h13579, 1'b0, 1'b0, 20'h24680, 1'b1, 1'b0));
      @(negedge clk);
      setS0(19'h55555, 1'b0, 8'h01);
      #1;
      checks++;
      if ({s0_found, s0_index, s0_pfn, s0_v} !== {1'b1, 4'd6, 20'h13579, 1'b0}) begin
         errors++;
         $display("[TB] FAIL invalid_page got=%h want=%h", {s0_found, s0_index, s0_pfn, s0_v},
                  {1'b1, 4'd6, 20'h13579, 1'b0});
      end
   endtask

   task automatic test_back_to_back();
      writeEntry(7, mkEntry(19'h0F0F0, 8'h22, 1'b0, 20'h11111, 1'b1, 1'b0, 20'h11112, 1'b1, 1'b0));
      writeEntry(7, mkEntry(19'h0F0F1, 8'h23, 1'b1, 20'h33333, 1'b1, 1'b1, 20'h33334, 1'b0, 1'b1));
      @(negedge clk);
      r_index = 4'd7;
      setS1(19'h0F0F0, 1'b0, 8'h22);
      #1;
      checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== mEntry[7]) begin
         errors++;
         $display("[TB] FAIL b2b_read got=%h want=%h",
                  {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}, mEntry[7]);
      end
      checks++;
      if (s1_found !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_old_tag got=%b want=0", s1_found);
      end
   endtask

   task automatic test_random();
      logic [29:0] exp0, exp1;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            writeEntry(int'($urandom_range(0, TLBNUM - 1)), randEntry());
         end else begin
            @(negedge clk);
            setS0(vpn2Pool[$urandom_range(0, 3)], 1'($urandom), ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h09);
            setS1(vpn2Pool[$urandom_range(0, 3)], 1'($urandom), ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h09);
            r_index = IDX_W'($urandom_range(0, TLBNUM - 1));
            #1;
            exp0 = modelSearch(s0_vpn2, s0_odd_page, s0_asid);
            exp1 = modelSearch(s1_vpn2, s1_odd_page, s1_asid);
            checks++;
            if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== exp0) begin
               errors++;
               $display("[TB] FAIL rand_s0 iter=%0d got=%h want=%h", n,
                        {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}, exp0);
            end
            checks++;
            if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== exp1) begin
               errors++;
               $display("[TB] FAIL rand_s1 iter=%0d got=%h want=%h", n,
                        {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, exp1);
            end
            checks++;
            if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== mEntry[r_index]) begin
               errors++;
               $display("[TB] FAIL rand_read iter=%0d idx=%0d got=%h want=%h", n, r_index,
                        {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1},
                        mEntry[r_index]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      writeEntry(3, mkEntry(19'h12345, 8'h07, 1'b0, 20'hAAAAA, 1'b1, 1'b0, 20'hBBBBB, 1'b1, 1'b1));
      writeEntry(10, mkEntry(19'h4321F, 8'h40, 1'b1, 20'h0DEAD, 1'b1, 1'b1, 20'h0BEEF, 1'b1, 1'b1));
      @(negedge clk);
      setS0(19'h12345, 1'b1, 8'h07);
      setS1(19'h4321F, 1'b0, 8'h00);
      r_index = 4'd10;
      #1;
      checks++;
      if ({s0_found, s1_found} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL async_prehit got=%b want=11", {s0_found, s1_found});
      end
      #1;
      reset = 1'b1;
      clearModel();
      #1;
      checks++;
      if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== 60'd0) begin
         errors++;
         $display("[TB] FAIL async_search got=%h want=0",
                  {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
      end
      checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== 78'd0) begin
         errors++;
         $display("[TB] FAIL async_read got=%h want=0",
                  {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1});
      end
      // A write held across an edge while reset is asserted must be dropped.
      driveWrite(4, mkEntry(19'h77777, 8'h05, 1'b1, 20'h44444, 1'b1, 1'b1, 20'h55555, 1'b1, 1'b1));
      @(posedge clk);
      #1;
      we = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      r_index = 4'd4;
      setS0(19'h77777, 1'b0, 8'h05);
      #1;
      checks++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== 78'd0) begin
         errors++;
         $display("[TB] FAIL reset_write_read got=%h want=0",
                  {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1});
      end
      checks++;
      if (s0_found !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_write_search got=%b want=0", s0_found);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_global();
      test_multi_match();
      test_invalid();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlb_lookup_responder.md
Name: tlb_lookup_responder

Overview:
- Responder end of the TLB search interface.
  - Holds the TLB entry array.
  - Answers the fetch-stage (s0) and execute-stage (s1) search requests combinationally, in the same cycle.
  - Serves TLBWI/TLBWR writes and TLBR reads from CP0.
- s1 also provides the matching index for TLBP.
- Sits beside CP0. Its s1 port connects directly to the EXE-stage TLB bridge: s1_vpn2/s1_odd_page in; s1_found/d/v/pfn out.

Parameters:
- TLBNUM, 16, number of entries (power of two).
- IDX_W, 4, index width = log2(TLBNUM).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- s0_vpn2  in  19  fetch search VPN2 (vaddr[31:13])
- s0_odd_page  in  1  vaddr[12]
- s0_asid  in  8  current ASID
- s0_found  out  1  hit
- s0_index  out  IDX_W  matching entry
- s0_pfn  out  20  selected page PFN
- s0_c  out  3  cache attribute
- s0_d  out  1  dirty
- s0_v  out  1  valid
- s1_vpn2, s1_odd_page, s1_asid  in  19/1/8  EXE/TLBP search
- s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  out  1/IDX_W/20/3/1/1  as s0
- we  in  1  write strobe (TLBWI/TLBWR)
- w_index  in  IDX_W  entry to write
- w_vpn2  in  19  VPN2 field written to entry
- w_asid  in  8  ASID field written to entry
- w_g  in  1  global bit written to entry
- w_pfn0, w_c0, w_d0, w_v0  in  20/3/1/1  even page fields
- w_pfn1, w_c1, w_d1, w_v1  in  20/3/1/1  odd page fields
- r_index  in  IDX_W  TLBR read index
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  widths as write fields  read data

Behaviour:
- Storage: TLBNUM entries. Each entry holds {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1} plus an internal entry-present bit E.
- Reset (async, any time): all entry fields and all E bits cleared to 0.
  - With every E=0, both search ports output found=0, index=0, pfn=0, c=0, d=0, v=0.
  - Read outputs are 0 for every r_index.
  - Reset asserted during a write cycle: the write is discarded.
- Match for entry i: E[i] && vpn2[i]==sx_vpn2 && (g[i] || asid[i]==sx_asid).
- Search is purely combinational from inputs and current array state; zero-cycle latency on both ports, which are fully independent.
- found = OR of all matches.
- Multiple matches (software error): lowest matching index wins. index, pfn, c, d and v all come from that entry; no exception is raised.
- Page select: odd_page=0 uses pfn0/c0/d0/v0; odd_page=1 uses pfn1/c1/d1/v1.
- Miss: found=0; index, pfn, c, d and v forced to 0, never stale.
- Found with v=0 is a legal response; the requester classifies it as invalid vs refill.
- Write: on a rising edge with we=1, entry w_index loads all w_* fields and sets E=1.
  - Only that entry changes.
  - A search or read of the same entry in the write cycle returns the old contents; new contents are visible from the next cycle.
- Back-to-back writes to the same index: the last write wins.
- Read: r_* = entry r_index fields, combinational, regardless of E. An entry that was never written reads as all zeros.
- TLBP: CP0 drives s1 with EntryHi; s1_found and s1_index give the probe result. No separate state is kept.
- No X propagation: outputs are defined for all input combinations after reset.

Test Plan:
- Reset, then search s0/s1 vpn2=0, asid=0, odd=0 -> found=0, pfn=0, v=0; r_index=5 -> all r_* = 0.
- Write idx 3 {vpn2=0x12345, asid=0x07, g=0, pfn0=0xAAAAA, v0=1, d0=0, pfn1=0xBBBBB, v1=1, d1=1}; next cycle:
  - s1 vpn2=0x12345, asid=7, odd=1 -> found=1, index=3, pfn=0xBBBBB, d=1, v=1.
  - odd=0 -> pfn=0xAAAAA, d=0.
  - asid=8 -> found=0.
- Same entry rewritten with g=1 -> s1 with asid=0xFF hits index 3. In the write cycle itself, s0 still shows the previous result.
- Identical vpn2/asid written to idx 9 and idx 2 -> search returns index=2 and idx 2's pfn.
- Entry with v0=0 -> found=1, v=0, pfn=its pfn0 (invalid case, not refill).
- Assert reset asynchronously mid-cycle after several writes -> all searches miss immediately, before the next edge. A write coinciding with reset leaves the entry zero after reset release.
